// File: rtl/sample_resp_misr_if.sv
// ---------------------------------------------------------------------------
// sample_resp_misr_if
// Purpose : Groups the handshake and data signals of the response compactor.
//           The compactor itself connects through the slave modport. The
//           driving side (upstream capture logic or bench) uses master.
// Signals :
//   start     - request a new compaction run (single-cycle pulse)
//   resp_i    - response vector {b_inv1, a_inv2, a_inv1, po_3..po_0}
//   sig_o     - signature register
//   sig_valid - signature is final and stable
//   sig_ack   - consumer accepts the signature
//   busy      - compaction run in progress
//   err       - sticky flag, a start request was rejected
// ---------------------------------------------------------------------------
interface sample_resp_misr_if #(
  parameter int WIDTH = 7
);
  logic             start;
  logic [WIDTH-1:0] resp_i;
  logic [WIDTH-1:0] sig_o;
  logic             sig_valid;
  logic             sig_ack;
  logic             busy;
  logic             err;

  modport master (
    output start,
    output resp_i,
    output sig_ack,
    input  sig_o,
    input  sig_valid,
    input  busy,
    input  err
  );

  modport slave (
    input  start,
    input  resp_i,
    input  sig_ack,
    output sig_o,
    output sig_valid,
    output busy,
    output err
  );
endinterface

// File: rtl/sample_resp_misr.sv
// ---------------------------------------------------------------------------
// sample_resp_misr
// Purpose : Response compactor for the sample logic block. It folds WINDOW
//           consecutive response vectors into a Galois-style multiple-input
//           signature register (MISR). The final signature is then offered
//           through a valid/ack handshake.
// Ports   :
//   clk    - clock, all state changes on the rising edge
//   rst_n  - asynchronous active-low reset
//   bus    - sample_resp_misr_if.slave
//            (start, resp_i, sig_ack in; sig_o, sig_valid, busy, err out)
// Parameters:
//   WIDTH  - response / signature width
//   POLY   - feedback mask, XORed in when the shifted-out MSB is 1
//   SEED   - signature value loaded when a run is accepted
//   WINDOW - number of response samples per run (>= 2)
// ---------------------------------------------------------------------------
module sample_resp_misr #(
  parameter int               WIDTH  = 7,
  parameter logic [WIDTH-1:0] POLY   = 7'h03,
  parameter logic [WIDTH-1:0] SEED   = 7'h01,
  parameter int               WINDOW = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  sample_resp_misr_if.slave      bus
);

  localparam int            CNT_W    = $clog2(WINDOW);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WINDOW - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next_state;
  logic [WIDTH-1:0] r_sig;
  logic [CNT_W-1:0] r_cnt;
  logic             r_err;

  // Accepted / rejected start decodes, produced alongside the next state
  logic             w_accept;
  logic             w_reject;
  logic [WIDTH-1:0] w_sig_step;
  logic             w_sig_valid;
  logic             w_busy;

  // ------------------------------------------------------------------------
  // State register
  // ------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // ------------------------------------------------------------------------
  // Next-state logic.
  // A start in DONE is only honoured together with sig_ack; that pairing
  // gives a back-to-back run without an IDLE bubble. Any other start outside
  // IDLE is rejected.
  // ------------------------------------------------------------------------
  always_comb begin
    w_next_state = r_state;
    w_accept     = 1'b0;
    w_reject     = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (bus.start) begin
          w_next_state = RUN;
          w_accept     = 1'b1;
        end
      end
      RUN: begin
        if (bus.start) begin
          w_reject = 1'b1;
        end
        if (r_cnt == CNT_LAST) begin
          w_next_state = DONE;
        end
      end
      DONE: begin
        if (bus.sig_ack) begin
          if (bus.start) begin
            w_next_state = RUN;
            w_accept     = 1'b1;
          end else begin
            w_next_state = IDLE;
          end
        end else if (bus.start) begin
          w_reject = 1'b1;
        end
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  // ------------------------------------------------------------------------
  // Output decode. Both flags come straight from the state register, so no
  // path exists from resp_i to any output.
  // ------------------------------------------------------------------------
  always_comb begin
    w_sig_valid = 1'b0;
    w_busy      = 1'b0;
    unique case (r_state)
      RUN:     w_busy      = 1'b1;
      DONE:    w_sig_valid = 1'b1;
      default: begin
        w_sig_valid = 1'b0;
        w_busy      = 1'b0;
      end
    endcase
  end

  // One MISR step: shift left, fold the dropped MSB back through POLY,
  // then mix in the current response vector.
  assign w_sig_step = {r_sig[WIDTH-2:0], 1'b0}
                    ^ (r_sig[WIDTH-1] ? POLY : '0)
                    ^ bus.resp_i;

  // ------------------------------------------------------------------------
  // Signature register and sample counter. The counter only advances in RUN.
  // It reaches CNT_LAST on the final sample and is cleared on every accepted
  // start, so it never wraps inside a run.
  // ------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sig <= '0;
      r_cnt <= '0;
    end else if (w_accept) begin
      r_sig <= SEED;
      r_cnt <= '0;
    end else if (r_state == RUN) begin
      r_sig <= w_sig_step;
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // ------------------------------------------------------------------------
  // Sticky rejected-start flag. Only reset clears it.
  // ------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err <= 1'b0;
    end else if (w_reject) begin
      r_err <= 1'b1;
    end
  end

  assign bus.sig_o     = r_sig;
  assign bus.sig_valid = w_sig_valid;
  assign bus.busy      = w_busy;
  assign bus.err       = r_err;

endmodule

// File: tb/tb_sample_resp_misr.sv
module tb_sample_resp_misr;

   localparam int         W      = 7;
   localparam int         N      = 16;
   localparam logic [6:0] SEED_A = 7'h01;
   localparam logic [6:0] SEED_B = 7'h00;

   typedef logic [W-1:0] sampleArr_t [N];

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   sample_resp_misr_if #(.WIDTH(W)) ifA ();
   sample_resp_misr_if #(.WIDTH(W)) ifB ();

   sample_resp_misr #(.WIDTH(W), .POLY(7'h03), .SEED(SEED_A), .WINDOW(N)) dutA (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (ifA)
   );

   sample_resp_misr #(.WIDTH(W), .POLY(7'h03), .SEED(SEED_B), .WINDOW(N)) dutB (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (ifB)
   );

   // Reference: the signature equals the polynomial
   // seed*x^N + sum(sample_k * x^(N-1-k)) reduced modulo x^7+x+1 over GF(2).
   // It is computed by long division on a wide word.
   function automatic logic [6:0] refSig(input logic [6:0] seed, input sampleArr_t s);
      logic [31:0] p;
      p = 32'(seed) << N;
      for (int k = 0; k < N; k++) p = p ^ (32'(s[k]) << (N - 1 - k));
      for (int b = 31; b >= 7; b--) begin
         if (p[b]) p = p ^ (32'h83 << (b - 7));
      end
      return p[6:0];
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic fillRandom(output sampleArr_t s);
      for (int k = 0; k < N; k++) s[k] = W'($urandom);
   endtask

   // Runs one compaction on dutA. Set b2b to pair start with sig_ack from DONE.
   // Set rejectAt >= 0 to pulse start at that RUN cycle.
   task automatic applyStimulus(input sampleArr_t s, input int rejectAt, input bit b2b,
                                output int busyCount);
      ifA.resp_i = W'($urandom);
      ifA.start  = 1'b1;
      if (b2b) ifA.sig_ack = 1'b1;
      tick();
      ifA.start   = 1'b0;
      ifA.sig_ack = 1'b0;
      checkOutput("runStartBusy", 32'(ifA.busy), 1);
      checkOutput("runSeedLoad", 32'(ifA.sig_o), 32'(SEED_A));
      busyCount = 0;
      for (int k = 0; k < N; k++) begin
         ifA.resp_i = s[k];
         if (k == rejectAt) ifA.start = 1'b1;
         if (ifA.busy) busyCount++;
         tick();
         ifA.start = 1'b0;
      end
      ifA.resp_i = W'($urandom);
   endtask

   task automatic ackA();
      ifA.sig_ack = 1'b1;
      tick();
      ifA.sig_ack = 1'b0;
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      sampleArr_t zeros, r1, r2, r3, imp;
      logic [6:0] held;
      int         bc;

      for (int k = 0; k < N; k++) begin
         zeros[k] = '0;
         imp[k]   = (k == 0) ? 7'h01 : 7'h00;
      end
      ifA.start = 1'b0; ifA.sig_ack = 1'b0; ifA.resp_i = '0;
      ifB.start = 1'b0; ifB.sig_ack = 1'b0; ifB.resp_i = '0;

      // reset state
      #12;
      checkOutput("rstSig", 32'(ifA.sig_o), 0);
      checkOutput("rstValid", 32'(ifA.sig_valid), 0);
      checkOutput("rstBusy", 32'(ifA.busy), 0);
      checkOutput("rstErr", 32'(ifA.err), 0);
      rst_n = 1'b1;
      tick();

      // ack in IDLE is ignored
      ifA.sig_ack = 1'b1;
      tick();
      ifA.sig_ack = 1'b0;
      checkOutput("idleAckBusy", 32'(ifA.busy), 0);
      checkOutput("idleAckValid", 32'(ifA.sig_valid), 0);

      // zero-response run
      applyStimulus(zeros, -1, 1'b0, bc);
      checkOutput("zeroValid", 32'(ifA.sig_valid), 1);
      checkOutput("zeroBusyEnd", 32'(ifA.busy), 0);
      checkOutput("zeroSig", 32'(ifA.sig_o), 32'h14);
      checkOutput("zeroBusyCycles", 32'(bc), N);

      // handshake hold
      held = ifA.sig_o;
      for (int i = 0; i < 10; i++) begin
         ifA.resp_i = W'($urandom);
         tick();
         checkOutput("holdValid", 32'(ifA.sig_valid), 1);
         checkOutput("holdSig", 32'(ifA.sig_o), 32'(held));
      end
      ackA();
      checkOutput("ackValid", 32'(ifA.sig_valid), 0);
      checkOutput("ackBusy", 32'(ifA.busy), 0);
      tick();
      checkOutput("idleSigKeep", 32'(ifA.sig_o), 32'h14);

      // random run, then back-to-back run
      fillRandom(r1);
      applyStimulus(r1, -1, 1'b0, bc);
      checkOutput("rnd1Valid", 32'(ifA.sig_valid), 1);
      checkOutput("rnd1Sig", 32'(ifA.sig_o), 32'(refSig(SEED_A, r1)));
      fillRandom(r2);
      applyStimulus(r2, -1, 1'b1, bc);
      checkOutput("b2bValid", 32'(ifA.sig_valid), 1);
      checkOutput("b2bSig", 32'(ifA.sig_o), 32'(refSig(SEED_A, r2)));
      checkOutput("b2bErr", 32'(ifA.err), 0);
      ackA();

      // rejected start in RUN
      fillRandom(r3);
      applyStimulus(r3, 5, 1'b0, bc);
      checkOutput("rejErr", 32'(ifA.err), 1);
      checkOutput("rejValid", 32'(ifA.sig_valid), 1);
      checkOutput("rejSig", 32'(ifA.sig_o), 32'(refSig(SEED_A, r3)));
      checkOutput("rejBusyCycles", 32'(bc), N);
      ackA();
      checkOutput("rejErrSticky", 32'(ifA.err), 1);
      checkOutput("rejAckValid", 32'(ifA.sig_valid), 0);

      // reset mid-run, observed before the next clock edge
      ifA.start = 1'b1;
      tick();
      ifA.start = 1'b0;
      for (int i = 0; i < 8; i++) begin
         ifA.resp_i = W'($urandom);
         tick();
      end
      rst_n = 1'b0;
      #1;
      checkOutput("asyncRstSig", 32'(ifA.sig_o), 0);
      checkOutput("asyncRstBusy", 32'(ifA.busy), 0);
      checkOutput("asyncRstValid", 32'(ifA.sig_valid), 0);
      checkOutput("asyncRstErr", 32'(ifA.err), 0);
      tick();
      rst_n = 1'b1;
      tick();
      checkOutput("postRstIdle", 32'(ifA.busy), 0);
      applyStimulus(zeros, -1, 1'b0, bc);
      checkOutput("postRstSig", 32'(ifA.sig_o), 32'h14);
      checkOutput("postRstErr", 32'(ifA.err), 0);

      // start in DONE without ack is rejected and leaves the signature alone
      ifA.start = 1'b1;
      tick();
      ifA.start = 1'b0;
      checkOutput("doneRejErr", 32'(ifA.err), 1);
      checkOutput("doneRejValid", 32'(ifA.sig_valid), 1);
      checkOutput("doneRejSig", 32'(ifA.sig_o), 32'h14);
      ackA();

      // single impulse on the SEED=0 instance
      ifB.start = 1'b1;
      tick();
      ifB.start = 1'b0;
      checkOutput("impSeed", 32'(ifB.sig_o), 0);
      for (int k = 0; k < N; k++) begin
         ifB.resp_i = imp[k];
         tick();
      end
      ifB.resp_i = '0;
      checkOutput("impValid", 32'(ifB.sig_valid), 1);
      checkOutput("impSig", 32'(ifB.sig_o), 32'(refSig(SEED_B, imp)));
      checkOutput("impSigConst", 32'(ifB.sig_o), 32'h0A);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/sample_resp_misr.md
Name: sample_resp_misr

Overview:
Downstream response compactor for the sample logic block. It captures the block's primary outputs each clock (po_0..po_3, a_inv1, a_inv2, b_inv1, concatenated into resp_i) over a programmable window. It folds them into a multiple-input signature register (MISR) and presents the final signature through a valid/ack handshake. It is used as the capture stage in remap/restructure equivalence benches.

Parameters:
WIDTH, 7, width of resp_i and signature; bit order is {b_inv1, a_inv2, a_inv1, po_3, po_2, po_1, po_0}
POLY, 7'h03, Galois feedback mask (x^7+x+1); applied when the shifted-out MSB is 1
SEED, 7'h01, signature value loaded on an accepted start
WINDOW, 16, number of resp_i samples compacted per run; must be >= 2

Ports:
clk  input  1  clock; all state updates on the rising edge
rst_n  input  1  asynchronous, active-low reset
start  input  1  request a new compaction run; single-cycle pulse
resp_i  input  WIDTH  response vector from the upstream block
sig_o  output  WIDTH  signature register
sig_valid  output  1  signature is final and stable
sig_ack  input  1  consumer accepts the signature
busy  output  1  high while in the RUN state
err  output  1  sticky flag: start was rejected

Behaviour:
- Reset (rst_n=0, asynchronous) forces state=IDLE, sig_o=0, cnt=0, sig_valid=0, busy=0, err=0. Reset mid-run discards the run; nothing resumes after release.
- State machine has three states: IDLE, RUN, DONE.
- IDLE:
  - start=1 -> RUN; sig_o<=SEED; cnt<=0.
  - Otherwise the state holds and sig_o keeps its last value.
- RUN (busy=1):
  - Each edge: sig_o <= {sig_o[WIDTH-2:0],1'b0} ^ (sig_o[WIDTH-1] ? POLY : 0) ^ resp_i; cnt<=cnt+1.
  - On the edge where cnt==WINDOW-1, take the final update and go to DONE.
  - Exactly WINDOW samples are taken, on the WINDOW edges following the start edge.
- DONE:
  - sig_valid=1 and sig_o is frozen.
  - sig_ack=1 -> IDLE on that edge, and sig_valid drops.
  - sig_ack=1 with start=1 in the same cycle -> RUN with SEED reload (back-to-back run); err is not set.
- Latency: start sampled at edge E gives sig_valid=1 after edge E+WINDOW. sig_valid holds until acked with no timeout.
- Rejected start: start=1 in RUN, or in DONE without sig_ack, is ignored. It sets err=1, which stays set until rst_n.
- sig_ack outside DONE is ignored.
- Counter width is $clog2(WINDOW). There is no wrap within a run; cnt is cleared on every accepted start.
- All outputs are registered or decoded directly from state; there is no combinational path from resp_i to any output.

Test Plan:
- Zero-response run: default parameters, start pulse, resp_i=0 throughout -> sig_valid rises 16 edges after start, sig_o=7'h14, busy high for exactly 16 cycles.
- Single impulse: SEED=0, resp_i=7'h01 on the first RUN sample and 0 afterwards -> sig_o=7'h0A at sig_valid.
- Handshake hold: hold sig_ack=0 for 10 cycles after sig_valid -> sig_valid and sig_o remain stable. Raise sig_ack for 1 cycle -> sig_valid=0 on the next cycle and state returns to IDLE.
- Back-to-back run: assert start and sig_ack in the same DONE cycle -> busy=1 on the next cycle, sig_o=SEED, err stays 0, and the second signature matches the reference model.
- Rejected start: pulse start at RUN cycle 5 -> err=1, the run still completes after 16 samples with an unaffected signature, and err persists after ack.
- Reset mid-run: drop rst_n at RUN cycle 8 -> sig_o=0, busy=0, sig_valid=0 immediately, without waiting for a clock edge. After release, a fresh start yields 7'h14 with zero input.
